// File: rtl/param_memory_wrapper_if.sv
// rtl/param_memory_wrapper_if.sv - write/read/status bundle for param_memory_wrapper
//
// Purpose: groups the write port, the pipelined read port and the status
// flags of param_memory_wrapper into one bundle.
// Ports (signals):
//   wr_enable, wr_addr[ADDR_W], wr_data[DATA_W]  write request (master -> slave)
//   rd_enable, rd_addr[ADDR_W]                   read request  (master -> slave)
//   rd_data[DATA_W], rd_ready                    read response (slave -> master)
//   busy, init_done, err                         status        (slave -> master)
interface param_memory_wrapper_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              busy;
  logic              init_done;
  logic              err;

  modport master (
    output wr_enable, wr_addr, wr_data, rd_enable, rd_addr,
    input  rd_data, rd_ready, busy, init_done, err
  );

  modport slave (
    input  wr_enable, wr_addr, wr_data, rd_enable, rd_addr,
    output rd_data, rd_ready, busy, init_done, err
  );
endinterface

// File: rtl/param_memory_wrapper.sv
// rtl/param_memory_wrapper.sv - parameterised simple dual-port RAM with init clear and pipelined reads
//
// Purpose: DEPTH x DATA_W inferred RAM. After reset an INIT state optionally
// clears every word (one per cycle), then READY serves one write and one
// pipelined read per cycle with a fixed RD_LAT latency.
// Ports:
//   clk   in  clock, rising edge
//   nRst  in  synchronous active-low reset
//   bus   slave side of param_memory_wrapper_if (write, read, status)
// Configuration macro:
//   MEMWRAP_BYPASS_EN  defined   -> same-cycle read of a word being written returns the new data
//                      undefined -> that read returns the previously stored data
module param_memory_wrapper #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 2,
  parameter int INIT_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  nRst,
  param_memory_wrapper_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic {INIT, READY} state_e;
  localparam state_e RST_STATE = (INIT_ZERO != 0) ? INIT : READY;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  init_addr_q, init_addr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_in_range, rd_in_range;
  logic              rd_accept;
  logic              err_d, err_q;
  logic              wr_prev_q;
  logic [DATA_W-1:0] rd_word;
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_C;
  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_C;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = bus.wr_addr[IDX_W-1:0];
    mem_wdata   = bus.wr_data;
    rd_accept   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      INIT: begin
        // The clear owns the write port; user requests are dropped and flagged.
        mem_we      = 1'b1;
        mem_waddr   = init_addr_q;
        mem_wdata   = '0;
        init_addr_d = init_addr_q + 1'b1;
        err_d       = bus.wr_enable | bus.rd_enable;
        if (init_addr_q == IDX_W'(DEPTH - 1)) begin
          state_d     = READY;
          init_addr_d = '0;
        end
      end
      READY: begin
        mem_we    = bus.wr_enable & wr_in_range;
        rd_accept = bus.rd_enable;
        err_d     = (bus.wr_enable & ~wr_in_range) | (bus.rd_enable & ~rd_in_range);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Out-of-range reads still travel down the pipe so rd_ready keeps its
  // latency; they carry zero instead of a RAM word.
  always_comb begin
`ifdef MEMWRAP_BYPASS_EN
    if (!rd_in_range) begin
      rd_word = '0;
    end else if (mem_we && (state_q == READY) && (bus.wr_addr == bus.rd_addr)) begin
      rd_word = bus.wr_data;
    end else begin
      rd_word = mem[bus.rd_addr[IDX_W-1:0]];
    end
`else
    rd_word = rd_in_range ? mem[bus.rd_addr[IDX_W-1:0]] : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= RST_STATE;
      init_addr_q <= '0;
      err_q       <= 1'b0;
      wr_prev_q   <= 1'b0;
      vld_q       <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      err_q       <= err_d;
      wr_prev_q   <= bus.wr_enable;
      vld_q[0]    <= rd_accept;
      if (rd_accept) begin
        dat_q[0] <= rd_word;
      end
      // Each data stage loads only behind a valid token, so the last stage
      // holds rd_data between rd_ready pulses.
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign bus.rd_ready  = nRst & vld_q[RD_LAT-1];
  assign bus.rd_data   = nRst ? dat_q[RD_LAT-1] : '0;
  assign bus.err       = nRst & err_q;
  assign bus.init_done = nRst & (state_q == READY);
  assign bus.busy      = ~nRst | (state_q != READY) | bus.wr_enable | bus.rd_enable
                       | wr_prev_q | (|vld_q);

endmodule

// File: tb/tb_param_memory_wrapper.sv
// tb/tb_param_memory_wrapper.sv - scoreboard bench for param_memory_wrapper
module tb_param_memory_wrapper;

  localparam int DW     = 16;
  localparam int AW     = 8;
  localparam int DEPTH  = 200;
  localparam int RD_LAT = 3;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  param_memory_wrapper_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  param_memory_wrapper #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .INIT_ZERO(1)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  exp_t          sb[$];
  bit            exp_err[int];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] hold_exp = '0;
  int            cyc      = 0;
  int            init_end = 1 << 30;
  int            checks   = 0;
  int            errors   = 0;
  bit            prev_wr  = 1'b0;
  bit            bypass;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    check("init_done", bus.init_done, (nRst && cyc >= init_end));
    check("busy", bus.busy, (!nRst || cyc < init_end || bus.wr_enable || bus.rd_enable
                             || prev_wr || sb.size() > 0));
    check("err", bus.err, (nRst && exp_err.exists(cyc) && exp_err[cyc]));
    if (!nRst) hold_exp = '0;
    if (bus.rd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_ready_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        e = sb.pop_front();
        check("rd_latency", cyc, e.cyc);
        check("rd_data", bus.rd_data, e.data);
        hold_exp = e.data;
      end
    end else begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rd_ready_missing cyc=%0d got=0 want=1 (due %0d)", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      check("rd_hold", bus.rd_data, hold_exp);
    end
  end

  // One cycle of stimulus; the model decides what the DUT must answer.
  task automatic drive(bit we, int wa, int wd, bit re, int ra);
    bit   in_init;
    bit   ev;
    exp_t e;
    in_init       = (cyc < init_end);
    bus.wr_enable = we;
    bus.wr_addr   = wa[AW-1:0];
    bus.wr_data   = wd[DW-1:0];
    bus.rd_enable = re;
    bus.rd_addr   = ra[AW-1:0];
    if (in_init) begin
      ev = we | re;
    end else begin
      ev = (we && wa >= DEPTH) || (re && ra >= DEPTH);
      if (re) begin
        e.cyc = cyc + RD_LAT;
        if (ra >= DEPTH)                      e.data = '0;
        else if (bypass && we && wa == ra)    e.data = wd[DW-1:0];
        else                                  e.data = model[ra];
        sb.push_back(e);
      end
      if (we && wa < DEPTH) model[wa] = wd[DW-1:0];
    end
    exp_err[cyc+1] = ev;
    @(posedge clk);
    #1;
    prev_wr = we;
    cyc++;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    nRst          = 1'b0;
    bus.wr_enable = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_enable = 1'b0;
    bus.rd_addr   = '0;
    sb.delete();
    exp_err.delete();
    init_end = 1 << 30;
    repeat (n) begin
      @(posedge clk);
      #1;
      prev_wr = 1'b0;
      cyc++;
    end
    nRst     = 1'b1;
    init_end = cyc + DEPTH;
    foreach (model[i]) model[i] = '0;
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 255));
      1:       return int'($urandom_range(DEPTH - 4, DEPTH + 3));
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic random_ops(int n);
    repeat (n) begin
      drive($urandom_range(0, 1) == 1, pick_addr(), int'($urandom_range(0, 16'hFFFF)),
            $urandom_range(0, 1) == 1, pick_addr());
    end
  endtask

  initial begin
`ifdef MEMWRAP_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    bus.wr_enable = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_enable = 1'b0;
    bus.rd_addr   = '0;
    do_reset(3);

    // Requests during INIT are dropped and flagged.
    repeat (4) drive(0, 0, 0, 1, int'($urandom_range(0, 255)));
    drive(1, 5, 16'hBEEF, 0, 0);
    drive(1, 6, 16'hCAFE, 1, 6);
    while (cyc < init_end) idle(1);

    drive(0, 0, 0, 1, 'h7F);
    drive(0, 0, 0, 1, 5);
    drive(0, 0, 0, 1, 6);

    // Back-to-back reads after a write, latency 3.
    drive(1, 'h10, 16'hA5A5, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 'h10);
    idle(2);

    // Out-of-range write and read for DEPTH=200.
    drive(1, 'hC8, 16'h1111, 1, 'hD0);
    drive(0, 0, 0, 1, 'hC8);
    drive(1, 'hFF, 16'h2222, 0, 0);
    drive(1, DEPTH - 1, 16'h7777, 1, DEPTH - 1);
    drive(0, 0, 0, 1, DEPTH - 1);
    idle(2);

    // Same-address read during write.
    drive(1, 'h20, 16'h5555, 0, 0);
    drive(1, 'h20, 16'h1234, 1, 'h20);
    drive(0, 0, 0, 1, 'h20);
    idle(4);

    random_ops(1500);

    // Reset with reads in flight, then a reset in the middle of INIT.
    drive(0, 0, 0, 1, 'h20);
    drive(0, 0, 0, 1, 'h10);
    do_reset(1);
    idle(40);
    do_reset(1);
    while (cyc < init_end) idle(1);
    drive(0, 0, 0, 1, 'h10);
    drive(0, 0, 0, 1, 'h20);
    random_ops(400);

    idle(RD_LAT + 2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/param_memory_wrapper.md
PARAM_MEMORY_WRAPPER -- requirements
Module: param_memory_wrapper

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits (1..32).
REQ-002 Parameter ADDR_W, default 8: address width in bits (1..12).
REQ-003 Parameter DEPTH, default 256: number of implemented words (1..2**ADDR_W).
REQ-004 Parameter RD_LAT, default 2: read latency in clk cycles (1..4).
REQ-005 Parameter INIT_ZERO, default 1: 1 = clear all words after reset, 0 = no clear.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 nRst  in  1  reset, synchronous, active-low.
REQ-008 wr_enable  in  1  write request, one word per cycle.
REQ-009 wr_addr  in  ADDR_W  write address.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 rd_enable  in  1  read request, one per cycle, pipelined.
REQ-012 rd_addr  in  ADDR_W  read address.
REQ-013 rd_data  out  DATA_W  read data, valid when rd_ready=1, held until the next rd_ready.
REQ-014 rd_ready  out  1  one-cycle pulse per accepted read.
REQ-015 busy  out  1  memory not idle.
REQ-016 init_done  out  1  high once the block is in READY.
REQ-017 err  out  1  one-cycle pulse on a dropped or out-of-range request.

Function
REQ-018 Storage SHALL be an inferred DEPTH x DATA_W simple dual-port RAM; no vendor primitive.
REQ-019 FSM states SHALL be INIT and READY; after reset: INIT if INIT_ZERO=1, else READY.
REQ-020 INIT SHALL write zero to addresses 0..DEPTH-1, one per cycle, then enter READY after exactly DEPTH cycles.
REQ-021 In INIT, wr_enable/rd_enable SHALL be ignored (no write, no rd_ready), and err SHALL pulse the next cycle for each cycle either is high.
REQ-022 In READY, a write with wr_addr<DEPTH SHALL update memory at that clock edge.
REQ-023 A write with wr_addr>=DEPTH SHALL be discarded, with err pulsing the next cycle.
REQ-024 A read accepted in cycle N SHALL produce rd_ready=1 in cycle N+RD_LAT; back-to-back reads SHALL give back-to-back rd_ready pulses in request order.
REQ-025 A read with rd_addr>=DEPTH SHALL still produce rd_ready at N+RD_LAT, with rd_data=0 and err pulsing the next cycle.
REQ-026 Simultaneous read and write to different addresses SHALL both complete.
REQ-027 Same-address simultaneous read/write SHALL follow REQ-041/REQ-042.
REQ-028 busy SHALL be the combinational OR of: state!=READY, wr_enable, rd_enable, a write in the previous cycle, and any read in flight.
REQ-029 Simultaneous in-range and out-of-range events in one cycle SHALL produce a single err pulse.

Reset
REQ-030 While nRst=0: rd_data=0, rd_ready=0, err=0, init_done=0, busy=1.
REQ-031 Reset asserted mid-operation SHALL cancel all in-flight reads (no rd_ready) and restart the FSM per REQ-019.
REQ-032 Reset asserted mid-INIT SHALL restart clearing from address 0.
REQ-033 Memory contents SHALL NOT be guaranteed after reset when INIT_ZERO=0.

Configuration
REQ-040 The macro MEMWRAP_BYPASS_EN SHALL select read-during-write behaviour.
REQ-041 MEMWRAP_BYPASS_EN defined: a read issued in the same cycle as a write to the same in-range address SHALL return the new wr_data.
REQ-042 MEMWRAP_BYPASS_EN undefined: that read SHALL return the old stored value.

Verification
REQ-050 INIT_ZERO=1, DEPTH=256: release reset -> busy=1, init_done=0 for 256 cycles, then init_done=1; read addr 0x7F returns 0x0000.
REQ-051 RD_LAT=3: write 0xA5A5@0x10 then read 0x10 in cycles 5,6,7 -> rd_ready in cycles 8,9,10, rd_data=0xA5A5 each time.
REQ-052 DEPTH=200: write @0xC8 and read @0xD0 -> no write, err pulses, rd_ready with rd_data=0x0000.
REQ-053 Same cycle: write 0x1234@0x20 and read 0x20 (old value 0x5555) -> 0x1234 with MEMWRAP_BYPASS_EN, 0x5555 without.
REQ-054 Two reads in flight, then nRst=0 for one cycle -> no rd_ready, rd_data=0, INIT restarts at address 0.
REQ-055 rd_enable high during INIT -> err pulses, no rd_ready, busy stays 1.
